// File: rtl/fetch_unit.sv
// fetch_unit: owns the PC, fetches one 8-bit instruction at a time over a
// req/ack handshake, holds it for decode and redirects on JI / BRZR.
// No prefetch: a new request is issued only after the held instruction is
// accepted, so a redirect never needs a flush.
// Optional: define FETCH_PERF_CNT_EN to add retired_cnt / stall_cnt outputs.
module fetch_unit #(
   parameter int              PC_W     = 8,
   parameter int              INSTR_W  = 8,
   parameter logic [PC_W-1:0] RESET_PC = '0
) (
   input  logic               clk,
   input  logic               rst_n,
   output logic               imem_req,
   output logic [PC_W-1:0]    imem_addr,
   input  logic               imem_ack,
   input  logic [INSTR_W-1:0] imem_data,
   output logic [INSTR_W-1:0] instr,
   output logic [PC_W-1:0]    instr_pc,
   output logic               instr_valid,
   input  logic               instr_ready,
   input  logic               br,
   input  logic               j,
   input  logic               zero,
   input  logic [PC_W-1:0]    br_target
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [15:0]        retired_cnt,
   output logic [15:0]        stall_cnt
`endif
);

   typedef enum logic [1:0] {IDLE, FETCH, ISSUE} state_t;

   state_t          state, state_nxt;
   logic [PC_W-1:0] pc, pc_nxt;
   logic [PC_W-1:0] imm_sext;
   logic            capture, accept;

   // JI offset: instr[3:0] as a signed -8..+7 displacement
   assign imm_sext  = {{(PC_W-4){instr[3]}}, instr[3:0]};
   assign imem_addr = pc;

   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // next state and handshake outputs; ack/ready only matter in their own state
   always_comb begin
      state_nxt   = state;
      imem_req    = 1'b0;
      instr_valid = 1'b0;
      capture     = 1'b0;
      accept      = 1'b0;
      case (state)
         IDLE:  state_nxt = FETCH;
         FETCH: begin
            imem_req = 1'b1;
            if (imem_ack) begin
               capture   = 1'b1;
               state_nxt = ISSUE;
            end
         end
         ISSUE: begin
            instr_valid = 1'b1;
            if (instr_ready) begin
               accept    = 1'b1;
               state_nxt = FETCH;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // redirect priority: JI over BRZR-taken over fall-through; all modulo 2^PC_W
   always_comb begin
      pc_nxt = instr_pc + PC_W'(1);
      if (j)               pc_nxt = instr_pc + imm_sext;
      else if (br && zero) pc_nxt = br_target;
   end

   // PC updates only on accept, so it is stable for the whole FETCH
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      pc <= RESET_PC;
      else if (accept) pc <= pc_nxt;
   end

   // instruction register and its fetch address, loaded on the ack cycle only
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         instr    <= '0;
         instr_pc <= '0;
      end else if (capture) begin
         instr    <= imem_data;
         instr_pc <= pc;
      end
   end

`ifdef FETCH_PERF_CNT_EN
   logic stall;
   assign stall = ((state == FETCH) && !imem_ack) || ((state == ISSUE) && !instr_ready);

   // saturating retire / stall counters
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         retired_cnt <= '0;
         stall_cnt   <= '0;
      end else begin
         if (accept && retired_cnt != 16'hFFFF) retired_cnt <= retired_cnt + 16'd1;
         if (stall  && stall_cnt   != 16'hFFFF) stall_cnt   <= stall_cnt + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed scenarios plus a randomized run checked against a
// transaction-level model of the fetch address sequence.
module tb_fetch_unit;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       imem_req, instr_valid;
   logic [7:0] imem_addr, instr, instr_pc;
   logic       imem_ack = 1'b0;
   logic [7:0] imem_data = 8'h00;
   logic       instr_ready = 1'b0, br = 1'b0, j = 1'b0, zero = 1'b0;
   logic [7:0] br_target = 8'h00;
`ifdef FETCH_PERF_CNT_EN
   logic [15:0] retired_cnt, stall_cnt;
`endif

   int checks = 0;
   int errors = 0;

   fetch_unit #(.PC_W(8), .INSTR_W(8), .RESET_PC(8'h00)) dut (
      .clk(clk), .rst_n(rst_n),
      .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_ack(imem_ack), .imem_data(imem_data),
      .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid),
      .instr_ready(instr_ready), .br(br), .j(j), .zero(zero), .br_target(br_target)
`ifdef FETCH_PERF_CNT_EN
      , .retired_cnt(retired_cnt), .stall_cnt(stall_cnt)
`endif
   );

   always #5 clk = ~clk;

   // reference: next fetch address from the accepted instruction's rules
   function automatic logic [7:0] ref_next(input logic [7:0] ipc, input logic [7:0] ins,
                                           input bit jj, input bit bb, input bit zz,
                                           input logic [7:0] tgt);
      int off;
      off = ins[3] ? int'(ins[3:0]) - 16 : int'(ins[3:0]);
      if (jj)            return 8'((int'(ipc) + off + 256) % 256);
      else if (bb && zz) return tgt;
      else               return 8'((int'(ipc) + 1) % 256);
   endfunction

   task automatic cyc();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst_n = 1'b0; imem_ack = 1'b0; instr_ready = 1'b0;
      br = 1'b0; j = 1'b0; zero = 1'b0;
      cyc(); cyc();
      rst_n = 1'b1;
   endtask

   task automatic wait_req(output bit ok);
      int n;
      n = 0;
      while (!imem_req && n < 20) begin cyc(); n++; end
      ok = imem_req;
   endtask

   // from a FETCH negedge: hold off ack for 'waits' cycles, then return data
   task automatic serve(input int waits, input logic [7:0] data, output bit held);
      logic [7:0] a0, i0;
      a0 = imem_addr; i0 = instr; held = 1'b1;
      imem_ack = 1'b0;
      for (int w = 0; w < waits; w++) begin
         imem_data   = 8'($urandom);
         instr_ready = 1'($urandom);
         cyc();
         if (!(imem_req === 1'b1 && imem_addr === a0 && instr === i0 && instr_valid === 1'b0))
            held = 1'b0;
      end
      instr_ready = 1'b0;
      imem_ack = 1'b1; imem_data = data;
      cyc();
      imem_ack = 1'b0; imem_data = 8'($urandom);
   endtask

   // from an ISSUE negedge: stall 'stalls' cycles with garbage decode, then accept
   task automatic accept(input int stalls, input bit jj, input bit bb, input bit zz,
                         input logic [7:0] tgt, output bit held);
      logic [7:0] i0, p0;
      i0 = instr; p0 = instr_pc; held = 1'b1;
      instr_ready = 1'b0;
      for (int s = 0; s < stalls; s++) begin
         j = 1'($urandom); br = 1'($urandom); zero = 1'($urandom);
         br_target = 8'($urandom); imem_ack = 1'($urandom);
         cyc();
         if (!(instr_valid === 1'b1 && imem_req === 1'b0 && instr === i0 && instr_pc === p0))
            held = 1'b0;
      end
      imem_ack = 1'b0;
      instr_ready = 1'b1; j = jj; br = bb; zero = zz; br_target = tgt;
      cyc();
      instr_ready = 1'b0; j = 1'b0; br = 1'b0; zero = 1'b0;
   endtask

   task automatic goto_pc(input logic [7:0] a);
      bit h;
      serve(0, 8'h00, h);
      accept(0, 1'b0, 1'b1, 1'b1, a, h);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      cyc();
      checks++;
      if (imem_req !== 1'b0 || instr_valid !== 1'b0 || instr !== 8'h00 || instr_pc !== 8'h00) begin
         errors++;
         $display("FAIL reset_outputs: req=%b valid=%b instr=%h ipc=%h, need 0/0/00/00",
                  imem_req, instr_valid, instr, instr_pc);
      end
`ifdef FETCH_PERF_CNT_EN
      checks++;
      if (retired_cnt !== 16'd0 || stall_cnt !== 16'd0) begin
         errors++;
         $display("FAIL reset_counters: retired=%0d stall=%0d, need 0/0", retired_cnt, stall_cnt);
      end
`endif
      rst_n = 1'b1;
      checks++;
      if (imem_req !== 1'b0 || instr_valid !== 1'b0) begin
         errors++;
         $display("FAIL idle_cycle: req=%b valid=%b, need 0/0", imem_req, instr_valid);
      end
      cyc();
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== 8'h00) begin
         errors++;
         $display("FAIL first_req: req=%b addr=%h, need 1/00", imem_req, imem_addr);
      end
   endtask

   task automatic test_sequential();
      logic [7:0] mem [0:3];
      for (int i = 0; i < 4; i++) mem[i] = 8'($urandom);
      do_reset();
      imem_ack = 1'b1; instr_ready = 1'b1; imem_data = mem[0];
      for (int k = 0; k < 6; k++) begin
         cyc();
         checks++;
         if (k % 2 == 0) begin
            if (imem_req !== 1'b1 || instr_valid !== 1'b0 || imem_addr !== 8'(k / 2)) begin
               errors++;
               $display("FAIL seq_fetch%0d: req=%b valid=%b addr=%h, need 1/0/%h",
                        k, imem_req, instr_valid, imem_addr, 8'(k / 2));
            end
         end else if (imem_req !== 1'b0 || instr_valid !== 1'b1 ||
                      instr !== mem[k / 2] || instr_pc !== 8'(k / 2)) begin
            errors++;
            $display("FAIL seq_issue%0d: req=%b valid=%b instr=%h ipc=%h, need 0/1/%h/%h",
                     k, imem_req, instr_valid, instr, instr_pc, mem[k / 2], 8'(k / 2));
         end
         imem_data = mem[imem_addr[1:0]];
      end
      imem_ack = 1'b0; instr_ready = 1'b0;
   endtask

   task automatic test_wait_and_stall();
      bit h, ok;
      do_reset(); cyc();
      goto_pc(8'h05);
      serve(3, 8'hA7, h);
      checks++;
      if (!h || instr !== 8'hA7 || instr_pc !== 8'h05 || instr_valid !== 1'b1 || imem_req !== 1'b0) begin
         errors++;
         $display("FAIL wait_states: held=%0d instr=%h ipc=%h valid=%b req=%b, need 1/a7/05/1/0",
                  h, instr, instr_pc, instr_valid, imem_req);
      end
      accept(5, 1'b0, 1'b0, 1'b0, 8'h00, h);
      checks++;
      if (!h) begin
         errors++;
         $display("FAIL decode_stall: held=0, need 1");
      end
      wait_req(ok);
      checks++;
      if (!ok || imem_addr !== 8'h06) begin
         errors++;
         $display("FAIL after_stall: req_seen=%0d addr=%h, need 1/06", ok, imem_addr);
      end
   endtask

   task automatic test_jump();
      bit h;
      do_reset(); cyc();
      goto_pc(8'h02);
      serve(0, 8'h58, h);
      accept(0, 1'b1, 1'b0, 1'b0, 8'h00, h);
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== 8'hFA) begin
         errors++;
         $display("FAIL ji_back: req=%b addr=%h, need 1/fa", imem_req, imem_addr);
      end
      goto_pc(8'hFE);
      serve(0, 8'h33, h);
      accept(0, 1'b1, 1'b0, 1'b0, 8'h00, h);
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== 8'h01) begin
         errors++;
         $display("FAIL ji_wrap: req=%b addr=%h, need 1/01", imem_req, imem_addr);
      end
   endtask

   task automatic test_branch();
      bit h;
      do_reset(); cyc();
      goto_pc(8'h10);
      serve(0, 8'h20, h);
      accept(0, 1'b0, 1'b1, 1'b1, 8'h40, h);
      checks++;
      if (imem_addr !== 8'h40) begin
         errors++;
         $display("FAIL brzr_taken: addr=%h, need 40", imem_addr);
      end
      goto_pc(8'h10);
      serve(0, 8'h20, h);
      accept(0, 1'b0, 1'b1, 1'b0, 8'h40, h);
      checks++;
      if (imem_addr !== 8'h11) begin
         errors++;
         $display("FAIL brzr_not_taken: addr=%h, need 11", imem_addr);
      end
      goto_pc(8'h10);
      serve(0, 8'h21, h);
      accept(0, 1'b1, 1'b1, 1'b1, 8'h40, h);
      checks++;
      if (imem_addr !== 8'h11) begin
         errors++;
         $display("FAIL j_priority: addr=%h, need 11", imem_addr);
      end
   endtask

   task automatic test_reset_mid_fetch();
      bit h;
      do_reset(); cyc();
      serve(0, 8'h5A, h);
      accept(0, 1'b0, 1'b0, 1'b0, 8'h00, h);
      imem_ack = 1'b0;
      cyc();
      rst_n = 1'b0;
      #1;
      checks++;
      if (imem_req !== 1'b0 || instr_valid !== 1'b0 || instr !== 8'h00 || instr_pc !== 8'h00) begin
         errors++;
         $display("FAIL mid_fetch_reset: req=%b valid=%b instr=%h ipc=%h, need 0/0/00/00",
                  imem_req, instr_valid, instr, instr_pc);
      end
      imem_ack = 1'b1; imem_data = 8'hFF;
      cyc();
      rst_n = 1'b1;
      cyc();
      imem_ack = 1'b0;
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== 8'h00 || instr !== 8'h00 || instr_valid !== 1'b0) begin
         errors++;
         $display("FAIL stray_ack: req=%b addr=%h instr=%h valid=%b, need 1/00/00/0",
                  imem_req, imem_addr, instr, instr_valid);
      end
   endtask

   task automatic test_random();
      bit h, ok, jj, bb, zz;
      logic [7:0] exp_pc, d, tgt;
      int w, s, n_ret, n_stall;
      do_reset(); cyc();
      exp_pc = 8'h00; n_ret = 0; n_stall = 0;
      for (int n = 0; n < 150; n++) begin
         wait_req(ok);
         checks++;
         if (!ok || imem_addr !== exp_pc) begin
            errors++;
            $display("FAIL rnd_addr%0d: req_seen=%0d addr=%h, need 1/%h", n, ok, imem_addr, exp_pc);
            if (!ok) break;
         end
         d = 8'($urandom); w = $urandom_range(0, 3);
         serve(w, d, h);
         checks++;
         if (!h || instr !== d || instr_pc !== exp_pc || instr_valid !== 1'b1) begin
            errors++;
            $display("FAIL rnd_fetch%0d: held=%0d instr=%h ipc=%h valid=%b, need 1/%h/%h/1",
                     n, h, instr, instr_pc, instr_valid, d, exp_pc);
         end
         s = $urandom_range(0, 2);
         jj = ($urandom_range(0, 3) == 0); bb = 1'($urandom); zz = 1'($urandom);
         tgt = 8'($urandom);
         accept(s, jj, bb, zz, tgt, h);
         checks++;
         if (!h) begin
            errors++;
            $display("FAIL rnd_hold%0d: held=0, need 1", n);
         end
         exp_pc = ref_next(exp_pc, d, jj, bb, zz, tgt);
         n_ret++; n_stall += w + s;
      end
`ifdef FETCH_PERF_CNT_EN
      checks++;
      if (retired_cnt !== 16'(n_ret) || stall_cnt !== 16'(n_stall)) begin
         errors++;
         $display("FAIL rnd_counters: retired=%0d stall=%0d, need %0d/%0d",
                  retired_cnt, stall_cnt, n_ret, n_stall);
      end
`endif
   endtask

`ifdef FETCH_PERF_CNT_EN
   task automatic test_perf();
      bit h;
      do_reset(); cyc();
      serve(1, 8'h01, h); accept(1, 1'b0, 1'b0, 1'b0, 8'h00, h);
      serve(0, 8'h02, h); accept(0, 1'b0, 1'b0, 1'b0, 8'h00, h);
      serve(2, 8'h03, h); accept(0, 1'b0, 1'b0, 1'b0, 8'h00, h);
      checks++;
      if (retired_cnt !== 16'd3 || stall_cnt !== 16'd4) begin
         errors++;
         $display("FAIL perf_counts: retired=%0d stall=%0d, need 3/4", retired_cnt, stall_cnt);
      end
   endtask
`endif

   initial begin
      @(negedge clk);
      test_reset();
      test_sequential();
      test_wait_and_stall();
      test_jump();
      test_branch();
      test_reset_mid_fetch();
      test_random();
`ifdef FETCH_PERF_CNT_EN
      test_perf();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
